// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned shift-add multiplier and restoring divider
// with HI/LO result registers. One iteration per clock, WIDTH iterations per op.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mult,
  input  logic             div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // MUL: shifted multiplicand. DIV: remainder (upper half) : quotient (lower half).
  logic [2*WIDTH-1:0]     opa_q, opa_d;
  // MUL: multiplier shifted right each step. DIV: divisor.
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   dz_q, dz_d;

  logic                   accept;
  logic                   last;
  logic [2*WIDTH-1:0]     acc_nx;
  logic [2*WIDTH-1:0]     pair_nx;
  logic [WIDTH:0]         trial;

  // State, counter, operand and result registers; reset clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  // One multiply step and one restoring-divide step, computed every cycle.
  always_comb begin
    acc_nx  = acc_q;
    pair_nx = '0;
    trial   = '0;
    if (opb_q[0]) acc_nx = acc_q + opa_q;
    // Shifted remainder needs WIDTH+1 bits: the bit shifted out of the top matters.
    trial = opa_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (!trial[WIDTH]) pair_nx = {trial[WIDTH-1:0], opa_q[WIDTH-2:0], 1'b1};
    else               pair_nx = {opa_q[2*WIDTH-2:0], 1'b0};
  end

  // Next-state and datapath control; strobes are only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    accept  = ((state_q == IDLE) || (state_q == DONE)) && (mult || div);
    last    = (cnt_q == CNT_W'(WIDTH - 1));
    case (state_q)
      MUL: begin
        acc_d = acc_nx;
        opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = acc_nx[2*WIDTH-1:WIDTH];
          lo_d    = acc_nx[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        opa_d = pair_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          hi_d    = pair_nx[2*WIDTH-1:WIDTH];
          lo_d    = pair_nx[WIDTH-1:0];
          dz_d    = (opb_q == '0);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      // Both operand slots start from the raw inputs; mult has priority over div.
      opa_d   = {{WIDTH{1'b0}}, a};
      opb_d   = b;
      acc_d   = '0;
      cnt_d   = '0;
      dz_d    = 1'b0;
      state_d = mult ? MUL : DIV;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign dz   = dz_q;
  assign busy = (state_q == MUL) || (state_q == DIV);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed results for mul_div_unit.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        mult;
  logic        div;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        dz;

  int total = 0;
  int bad   = 0;
  int nb;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .mult (mult),
    .div  (div),
    .a    (a),
    .b    (b),
    .hi   (hi),
    .lo   (lo),
    .busy (busy),
    .done (done),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: present strobes for one clock edge, then scramble operands.
  task automatic issue(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
    mult = m;
    div  = d;
    a    = av;
    b    = bv;
    @(posedge clk);
    #1;
    mult = 1'b0;
    div  = 1'b0;
    a    = $urandom;
    b    = $urandom;
  endtask

  // Count busy cycles until done is seen at a negedge; bounded.
  task automatic wait_done(output int nbusy);
    int guard;
    nbusy = 0;
    guard = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (busy) nbusy++;
      guard++;
      if (guard > 100) begin
        chk("done_timeout", 64'(guard), 64'd0);
        break;
      end
    end
  endtask

  initial begin
    int seen;
    rst  = 1'b1;
    mult = 1'b0;
    div  = 1'b0;
    a    = '0;
    b    = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dz",   64'(dz),   64'd0);
    rst = 1'b0;

    // 7 x 6
    @(negedge clk);
    issue(1'b1, 1'b0, 32'd7, 32'd6);
    wait_done(nb);
    chk("mul7x6_busy", 64'(nb), 64'd32);
    chk("mul7x6_hi",   64'(hi), 64'h0);
    chk("mul7x6_lo",   64'(lo), 64'h2A);
    chk("mul7x6_dz",   64'(dz), 64'd0);
    @(negedge clk);
    chk("done_pulse_len", 64'(done), 64'd0);
    chk("idle_busy",      64'(busy), 64'd0);

    // Full-range multiply
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("mulmax_busy", 64'(nb), 64'd32);
    chk("mulmax_hi",   64'(hi), 64'hFFFF_FFFE);
    chk("mulmax_lo",   64'(lo), 64'h1);
    chk("mulmax_dz",   64'(dz), 64'd0);

    // 100 / 7, then back-to-back 0xFFFFFFFF / 0x10 issued in the done cycle
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    wait_done(nb);
    chk("div100_busy", 64'(nb), 64'd32);
    chk("div100_lo",   64'(lo), 64'd14);
    chk("div100_hi",   64'(hi), 64'd2);
    chk("div100_dz",   64'(dz), 64'd0);
    issue(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h10);
    wait_done(nb);
    chk("b2b_busy", 64'(nb), 64'd32);
    chk("b2b_lo",   64'(lo), 64'h0FFF_FFFF);
    chk("b2b_hi",   64'(hi), 64'hF);

    // Divide by zero
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done(nb);
    chk("dz_busy", 64'(nb), 64'd32);
    chk("dz_lo",   64'(lo), 64'hFFFF_FFFF);
    chk("dz_hi",   64'(hi), 64'd5);
    chk("dz_flag", 64'(dz), 64'd1);
    @(negedge clk);
    chk("dz_hold", 64'(dz), 64'd1);
    issue(1'b1, 1'b0, 32'd3, 32'd3);
    @(negedge clk);
    chk("dz_clear",   64'(dz), 64'd0);
    chk("hold_lo",    64'(lo), 64'hFFFF_FFFF);
    wait_done(nb);
    chk("mul3x3_lo",  64'(lo), 64'd9);
    chk("mul3x3_hi",  64'(hi), 64'd0);

    // Strobe dropped while busy
    @(negedge clk);
    issue(1'b0, 1'b1, 32'd9, 32'd4);
    repeat (5) @(negedge clk);
    issue(1'b1, 1'b0, 32'd2, 32'd2);
    wait_done(nb);
    chk("drop_lo", 64'(lo), 64'd2);
    chk("drop_hi", 64'(hi), 64'd1);
    @(negedge clk);
    chk("drop_idle", 64'(busy), 64'd0);

    // Simultaneous strobes: multiply wins
    issue(1'b1, 1'b1, 32'd3, 32'd4);
    wait_done(nb);
    chk("both_lo", 64'(lo), 64'd12);
    chk("both_hi", 64'(hi), 64'd0);

    // Reset ten cycles into a multiply
    @(negedge clk);
    issue(1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_hi",   64'(hi),   64'd0);
    chk("mrst_lo",   64'(lo),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("mrst_no_done", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
